// File: rtl/fp_add_pkg.sv
// Shared definitions for the FP32 adder arbiter: FSM state encoding and
// FP32 constants used when building operands and abort results.
package fp_add_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Negative quiet NaN, returned when an op is aborted.
  localparam logic [31:0] FP32_QNAN     = 32'hFFC0_0000;
  localparam int          FP32_SIGN_BIT = 31;

endpackage

// File: rtl/fp_add_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after the
// pointer, wrapping from NREQ-1 back to 0. Returns one-hot grant and index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] gnt_idx,
  output logic            gnt_any
);

  // Scan NREQ positions starting at the pointer; first hit wins.
  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one multi-cycle FP32 adder among NREQ requesters, one op at a time.
// Optional build macro FPADD_ARB_TIMEOUT_EN: aborts an op whose adder result
// does not arrive within TIMEOUT cycles of entering WAIT.
//
//   state | meaning
//   IDLE  | nothing outstanding, watching req_valid
//   GRANT | pick requester, pulse its ready, capture operands
//   ISSUE | one-cycle fu_start with captured operands
//   WAIT  | adder busy, waiting for fu_done (or timeout)
//   RESP  | result presented to granted requester until it consumes it
module fp_add_arbiter
  import fp_add_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  input  logic [NREQ-1:0]      req_sub,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_z,
  output logic                 rsp_ofw,
  output logic                 rsp_err,
  output logic                 fu_start,
  output logic [31:0]          fu_a,
  output logic [31:0]          fu_b,
  input  logic                 fu_done,
  input  logic [31:0]          fu_z,
  input  logic                 fu_ofw,
  output logic                 busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 1 || TIMEOUT < 1) begin : g_param_check
    $error("fp_add_arbiter: NREQ and TIMEOUT must be at least 1");
  end

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] gidx_q, gidx_d;
  logic [31:0]     opa_q, opa_d;
  logic [31:0]     opb_q, opb_d;
  logic [31:0]     z_q, z_d;
  logic            ofw_q, ofw_d;

  logic [NREQ-1:0] gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_any;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;

`ifdef FPADD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  rr_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Operands of the winning requester; subtraction folds into b's sign bit.
  always_comb begin
    sel_a = req_a[32*gnt_idx +: 32];
    sel_b = req_b[32*gnt_idx +: 32];
    sel_b[FP32_SIGN_BIT] = sel_b[FP32_SIGN_BIT] ^ req_sub[gnt_idx];
  end

  // Next-state, capture and handshake outputs.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    z_d       = z_q;
    ofw_d     = ofw_q;
    req_ready = '0;
    rsp_valid = '0;
    fu_start  = 1'b0;
`ifdef FPADD_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (gnt_any) begin
          req_ready = gnt;
          gidx_d    = gnt_idx;
          opa_d     = sel_a;
          opb_d     = sel_b;
          ptr_d     = (gnt_idx == IDXW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
          state_d   = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        fu_start = 1'b1;
        state_d  = ST_WAIT;
`ifdef FPADD_ARB_TIMEOUT_EN
        cnt_d    = CW'(TIMEOUT - 1);
`endif
      end
      ST_WAIT: begin
        if (fu_done) begin
          z_d     = fu_z;
          ofw_d   = fu_ofw;
          state_d = ST_RESP;
`ifdef FPADD_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (cnt_q == '0) begin
          z_d     = FP32_QNAN;
          ofw_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
`endif
        end
      end
      ST_RESP: begin
        rsp_valid[gidx_q] = 1'b1;
        if (rsp_ready[gidx_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      z_q     <= '0;
      ofw_q   <= 1'b0;
`ifdef FPADD_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      z_q     <= z_d;
      ofw_q   <= ofw_d;
`ifdef FPADD_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign fu_a    = opa_q;
  assign fu_b    = opb_q;
  assign rsp_z   = z_q;
  assign rsp_ofw = ofw_q;
  assign busy    = (state_q != ST_IDLE);
`ifdef FPADD_ARB_TIMEOUT_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Scoreboard bench: driver pushes the expected response at each accept, a
// separate monitor pops it when the DUT hands a result back.
module tb_fp_add_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid, req_ready, req_sub;
  logic [NREQ*32-1:0]  req_a, req_b;
  logic [NREQ-1:0]     rsp_valid, rsp_ready;
  logic [31:0]         rsp_z;
  logic                rsp_ofw, rsp_err;
  logic                fu_start, fu_done, fu_ofw, busy;
  logic [31:0]         fu_a, fu_b, fu_z;

  fp_add_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_sub(req_sub), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_ofw(rsp_ofw), .rsp_err(rsp_err),
    .fu_start(fu_start), .fu_a(fu_a), .fu_b(fu_b), .fu_done(fu_done),
    .fu_z(fu_z), .fu_ofw(fu_ofw), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stand-in adder: a few known FP32 sums, otherwise an arbitrary mix.
  function automatic logic [32:0] add_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return {1'b0, 32'h4040_0000};
    if (a == 32'h4040_0000 && b == 32'hBF80_0000) return {1'b0, 32'h4000_0000};
    if (a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF) return {1'b1, 32'h7F80_0000};
    return {a[0] ^ b[0], a + (b ^ 32'h5A5A_0F0F)};
  endfunction

  typedef struct { int idx; logic [31:0] z; logic ofw; logic err; } exp_t;
  typedef struct { int idx; logic [31:0] a; logic [31:0] b; logic sub; } op_t;

  exp_t sb[$];
  op_t  pend_ops[$];
  int   grant_log[$];

  int drv_mode    = 0;   // 0 directed, 1 keep valid, 2 random
  int rsp_mode    = 1;   // 0 random, 1 always ready, 2 never ready
  int exp_timeout = 0;
  int mptr        = 0;
  int fu_lat      = 0;   // 0: random latency 1..6
  int fu_mute     = 0;
  int fu_pend     = 0;
  int fu_cnt      = 0;
  int fu_start_cyc = 0;
  int done_cnt    = 0;
  int rsp_count   = 0;
  logic [31:0] last_fa, last_fb;

  // Driver: checks grant choice, scores accepts, updates requester inputs.
  initial begin
    logic [NREQ-1:0] acc;
    req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      if (req_ready != '0 && !reset) begin
        int g;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (mptr + k) % NREQ;
          if (g < 0 && req_valid[j]) g = j;
        end
        chk("grant", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
        if (g >= 0) begin
          exp_t e;
          logic [32:0] r;
          e.idx = g;
          if (exp_timeout != 0) begin
            e.z = 32'hFFC0_0000; e.ofw = 1'b0; e.err = 1'b1;
          end else begin
            r = add_model(req_a[32*g +: 32], req_b[32*g +: 32] ^ {req_sub[g], 31'b0});
            e.z = r[31:0]; e.ofw = r[32]; e.err = 1'b0;
          end
          sb.push_back(e);
          grant_log.push_back(g);
          mptr = (g + 1) % NREQ;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          if (drv_mode == 0 || (drv_mode == 2 && $urandom_range(1) == 0)) begin
            req_valid[i] = 1'b0;
          end else begin
            req_a[32*i +: 32] = $urandom; req_b[32*i +: 32] = $urandom;
            req_sub[i] = 1'($urandom_range(1));
          end
        end else if (drv_mode == 2 && !req_valid[i] && $urandom_range(3) == 0) begin
          req_valid[i] = 1'b1;
          req_a[32*i +: 32] = $urandom; req_b[32*i +: 32] = $urandom;
          req_sub[i] = 1'($urandom_range(1));
        end
      end
      for (int n = 0; n < pend_ops.size(); n++) begin
        if (!req_valid[pend_ops[n].idx]) begin
          req_valid[pend_ops[n].idx]          = 1'b1;
          req_a[32*pend_ops[n].idx +: 32]     = pend_ops[n].a;
          req_b[32*pend_ops[n].idx +: 32]     = pend_ops[n].b;
          req_sub[pend_ops[n].idx]            = pend_ops[n].sub;
          pend_ops.delete(n);
          n--;
        end
      end
      rsp_ready = (rsp_mode == 0) ? NREQ'($urandom) : (rsp_mode == 1) ? '1 : '0;
    end
  end

  // Adder model: answers each fu_start after a latency; checks operand hold.
  initial begin
    logic [31:0] fa, fb;
    logic [32:0] r;
    fu_done = 1'b0; fu_z = '0; fu_ofw = 1'b0; fa = '0; fb = '0;
    forever begin
      @(negedge clk);
      if (fu_start && !reset) begin
        chk("two_outstanding", 64'(fu_pend), 64'd0);
        fu_pend = 1; fa = fu_a; fb = fu_b; last_fa = fu_a; last_fb = fu_b;
        fu_start_cyc = cyc;
        fu_cnt = (fu_lat == 0) ? int'($urandom_range(6, 1)) : fu_lat;
      end else if (fu_pend != 0 && busy && !reset) begin
        chk("fu_a_hold", fu_a, fa);
        chk("fu_b_hold", fu_b, fb);
      end
      @(posedge clk);
      #1;
      fu_done = 1'b0;
      if (fu_pend != 0) begin
        fu_cnt--;
        if (fu_cnt == 0) begin
          fu_pend = 0;
          if (fu_mute == 0) begin
            r = add_model(fa, fb);
            fu_done = 1'b1; fu_z = r[31:0]; fu_ofw = r[32];
            done_cnt++;
          end
        end
      end
    end
  end

  // Monitor: every cycle a response is shown it must match the queue head.
  initial begin
    logic [NREQ-1:0] prev_v;
    prev_v = '0;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid != '0) begin
        chk("no_grant_in_resp", req_ready, 64'd0);
        if (sb.size() == 0) begin
          chk("rsp_unexpected", rsp_valid, 64'd0);
        end else begin
          chk("rsp_idx", rsp_valid, 64'd1 << sb[0].idx);
          chk("rsp_z",   rsp_z,     sb[0].z);
          chk("rsp_ofw", rsp_ofw,   sb[0].ofw);
          chk("rsp_err", rsp_err,   sb[0].err);
          if (exp_timeout != 0 && prev_v == '0)
            chk("timeout_latency", 64'(cyc - fu_start_cyc), 64'(TIMEOUT + 1));
          if ((rsp_valid & rsp_ready) != '0) begin
            void'(sb.pop_front());
            rsp_count++;
          end
        end
      end
      prev_v = reset ? '0 : rsp_valid;
    end
  end

  task automatic post(input int idx, input logic [31:0] a, input logic [31:0] b, input logic sub);
    op_t o;
    o.idx = idx; o.a = a; o.b = b; o.sub = sub;
    pend_ops.push_back(o);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t;
    t = 0;
    while ((busy || sb.size() != 0 || req_valid != '0 || pend_ops.size() != 0) && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(t < budget), 64'd1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    mptr = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int t;
    int base;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_fu_start",  fu_start, 0);
    chk("rst_fu_a",      fu_a, 0);
    chk("rst_fu_b",      fu_b, 0);
    chk("rst_rsp_z",     rsp_z, 0);
    chk("rst_rsp_flags", {rsp_ofw, rsp_err}, 0);
    chk("rst_busy",      busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Plain add from requester 0.
    base = rsp_count;
    post(0, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    wait_idle("idle_add", 100);
    chk("add_fu_a", last_fa, 32'h3F80_0000);
    chk("add_fu_b", last_fb, 32'h4000_0000);
    chk("add_rsp_cnt", 64'(rsp_count - base), 1);

    // Subtract from requester 1: b sign flipped before issue.
    post(1, 32'h4040_0000, 32'h3F80_0000, 1'b1);
    wait_idle("idle_sub", 100);
    chk("sub_fu_b", last_fb, 32'hBF80_0000);
    chk("sub_rsp_cnt", 64'(rsp_count - base), 2);

    // All four valid continuously after reset: round-robin order.
    pulse_reset();
    grant_log.delete();
    drv_mode = 1;
    for (int i = 0; i < NREQ; i++) post(i, $urandom, $urandom, 1'($urandom_range(1)));
    t = 0;
    while (grant_log.size() < 5 && t < 200) begin @(negedge clk); t++; end
    drv_mode = 0;
    wait_idle("idle_rr", 400);
    chk("rr_len", 64'(grant_log.size() >= 5), 1);
    if (grant_log.size() >= 5) begin
      chk("rr_g0", grant_log[0], 0);
      chk("rr_g1", grant_log[1], 1);
      chk("rr_g2", grant_log[2], 2);
      chk("rr_g3", grant_log[3], 3);
      chk("rr_g4", grant_log[4], 0);
    end

    // Overflow result held with rsp_ready low; a waiting request is not granted.
    rsp_mode = 2;
    post(3, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0);
    t = 0;
    while (rsp_valid == '0 && t < 100) begin @(negedge clk); t++; end
    chk("ofw_rsp_seen", 64'(t < 100), 1);
    post(0, 32'h1234_5678, 32'h0BAD_F00D, 1'b0);
    repeat (10) @(negedge clk);
    chk("hold_busy", busy, 1);
    chk("hold_no_ready", req_ready, 0);
    rsp_mode = 1;
    wait_idle("idle_hold", 200);

    // Reset while WAIT, then a late fu_done must be ignored.
    fu_lat = 8;
    base = rsp_count;
    post(2, 32'h4110_0000, 32'h4120_0000, 1'b0);
    t = 0;
    while (fu_pend == 0 && t < 50) begin @(negedge clk); t++; end
    chk("rw_issue_seen", 64'(t < 50), 1);
    repeat (2) @(posedge clk);
    t = done_cnt;
    pulse_reset();
    @(negedge clk);
    chk("rw_busy_after_reset", busy, 0);
    while (fu_pend != 0) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rw_late_done_fired", 64'(done_cnt - t), 1);
    chk("rw_busy_after_late", busy, 0);
    chk("rw_no_rsp", 64'(rsp_count - base), 0);
    fu_lat = 0;
    post(1, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    wait_idle("idle_after_rw", 100);
    chk("rw_next_served", 64'(rsp_count - base), 1);

    // Random traffic with random backpressure and adder latency.
    drv_mode = 2;
    rsp_mode = 0;
    repeat (3000) @(negedge clk);
    drv_mode = 0;
    rsp_mode = 1;
    wait_idle("idle_random", 500);

`ifdef FPADD_ARB_TIMEOUT_EN
    // Adder never answers: abort after TIMEOUT cycles in WAIT.
    fu_mute = 1;
    fu_lat = TIMEOUT + 40;
    exp_timeout = 1;
    base = rsp_count;
    post(2, 32'h4000_0000, 32'h4000_0000, 1'b0);
    wait_idle("idle_timeout", TIMEOUT + 50);
    chk("to_rsp_cnt", 64'(rsp_count - base), 1);
    exp_timeout = 0;
    t = 0;
    while (fu_pend != 0 && t < 200) begin @(negedge clk); t++; end
    fu_mute = 0;
    fu_lat = 0;
`endif

    chk("sb_empty", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
